// File: rtl/sr_pkg.sv
// Shared types for the SR latch driver.
// FSM state encoding and command select constants.
package sr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD,
    WAIT_REL
  } state_t;

  localparam logic CMD_SET = 1'b0;
  localparam logic CMD_RST = 1'b1;

endpackage

// File: rtl/sr_latch_driver_if.sv
// Button inputs and latch strobes of the SR latch driver.
// master = driver side, slave = buttons/latch side.
interface sr_latch_driver_if;
  logic set_btn;
  logic rst_btn;
  logic S;
  logic R;
  logic En;
  logic busy;
  logic q_expect;

  modport master (
    input  set_btn,
    input  rst_btn,
    output S,
    output R,
    output En,
    output busy,
    output q_expect
  );

  modport slave (
    output set_btn,
    output rst_btn,
    input  S,
    input  R,
    input  En,
    input  busy,
    input  q_expect
  );
endinterface

// File: rtl/btn_conditioner.sv
// Synchronizer, optional debouncer, level register and press detect.
// Debouncer present only when SR_DRIVER_DEBOUNCE_EN is defined.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  logic [1:0] sync;
  logic       level_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], btn};
    end
  end

`ifdef SR_DRIVER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt;
  logic          diff;

  assign diff = sync[1] ^ level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!diff || cnt == CMAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level_nxt = (diff && cnt == CMAX) ? ~level : level;
`else
  assign level_nxt = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      level <= level_nxt;
      press <= level_nxt & ~level;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences clean S/R/En strobes for a gated SR latch.
// Build option: SR_DRIVER_DEBOUNCE_EN enables input debouncing.
module sr_latch_driver
  import sr_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EN_WIDTH        = 2
) (
  input logic                clk,
  input logic                rst_n,
  sr_latch_driver_if.master  bus
);

  localparam logic [7:0] EN_LOAD = 8'(EN_WIDTH - 1);

  logic set_lvl, set_press;
  logic rst_lvl, rst_press;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.set_btn),
    .level (set_lvl),
    .press (set_press)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.rst_btn),
    .level (rst_lvl),
    .press (rst_press)
  );

  state_t     state, state_nxt;
  logic       cmd, cmd_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       q, q_nxt;
  logic       s_q, r_q, en_q, busy_q;
  logic       s_nxt, r_nxt, en_nxt, busy_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cmd    <= CMD_SET;
      cnt    <= '0;
      q      <= 1'b0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      en_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cmd    <= cmd_nxt;
      cnt    <= cnt_nxt;
      q      <= q_nxt;
      s_q    <= s_nxt;
      r_q    <= r_nxt;
      en_q   <= en_nxt;
      busy_q <= busy_nxt;
    end
  end

  // Reset request has priority; requests outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    cnt_nxt   = cnt;
    q_nxt     = q;
    unique case (state)
      IDLE: begin
        if (rst_press) begin
          state_nxt = SETUP;
          cmd_nxt   = CMD_RST;
        end else if (set_press) begin
          state_nxt = SETUP;
          cmd_nxt   = CMD_SET;
        end
      end
      SETUP: begin
        state_nxt = ENABLE;
        cnt_nxt   = EN_LOAD;
      end
      ENABLE: begin
        if (cnt == 8'd0) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      HOLD: begin
        state_nxt = WAIT_REL;
        q_nxt     = (cmd == CMD_SET);
      end
      WAIT_REL: begin
        if (!set_lvl && !rst_lvl) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state, so En and S/R
  // never change on the same edge.
  always_comb begin
    logic act;
    act      = (state_nxt == SETUP) ||
               (state_nxt == ENABLE) ||
               (state_nxt == HOLD);
    s_nxt    = act && (cmd_nxt == CMD_SET);
    r_nxt    = act && (cmd_nxt == CMD_RST);
    en_nxt   = (state_nxt == ENABLE);
    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.En       = en_q;
  assign bus.busy     = busy_q;
  assign bus.q_expect = q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver.
// Vector table for the default build, bounce run with the debouncer.
module tb_sr_latch_driver;

  logic clk;
  logic rst_n;

  sr_latch_driver_if bus ();

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(16),
    .EN_WIDTH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sb;
    logic       rb;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_fail;

  function automatic logic [4:0] outs();
    return {bus.S, bus.R, bus.En, bus.busy, bus.q_expect};
  endfunction

  task automatic chk(input string name, input logic [4:0] act,
                     input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got SREnBQ=%b want %b", name, act, exp);
    end
  endtask

  task automatic row(input logic sb, input logic rb,
                     input logic [4:0] exp);
    vec_t v;
    v.sb  = sb;
    v.rb  = rb;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic rows(input int n, input logic sb, input logic rb,
                      input logic [4:0] exp);
    for (int i = 0; i < n; i++) row(sb, rb, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.set_btn = 1'b0;
    bus.rst_btn = 1'b0;

    for (int i = 0; i < 8; i++) begin
      bus.set_btn = i[0];
      bus.rst_btn = i[1];
      cycle();
      chk($sformatf("reset_hold_%0d", i), outs(), 5'b00000);
    end
    bus.set_btn = 1'b0;
    bus.rst_btn = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;

`ifndef SR_DRIVER_DEBOUNCE_EN
    rows(10, 0, 0, 5'b00000);
    rows(3, 1, 0, 5'b00000);
    row(0, 0, 5'b10010);
    rows(2, 0, 0, 5'b10110);
    row(0, 0, 5'b10010);
    row(0, 0, 5'b00011);
    rows(4, 0, 0, 5'b00001);
    rows(3, 1, 1, 5'b00001);
    row(0, 0, 5'b01011);
    rows(2, 0, 0, 5'b01111);
    row(0, 0, 5'b01011);
    row(0, 0, 5'b00010);
    rows(2, 0, 0, 5'b00000);
    rows(3, 1, 0, 5'b00000);
    row(0, 0, 5'b10010);
    rows(2, 0, 1, 5'b10110);
    row(0, 0, 5'b10010);
    rows(2, 0, 0, 5'b00011);
    rows(4, 0, 0, 5'b00001);

    foreach (vecs[i]) begin
      bus.set_btn = vecs[i].sb;
      bus.rst_btn = vecs[i].rb;
      cycle();
      chk($sformatf("vec_edge_%0d", i), outs(), vecs[i].exp);
    end
`else
    begin
      int first_s;
      int s_rises;
      int r_seen;
      logic s_prev;
      first_s = -1;
      s_rises = 0;
      r_seen  = 0;
      s_prev  = 1'b0;
      for (int i = 0; i < 110; i++) begin
        bus.set_btn = (i >= 60) ? 1'b1 : (((i / 5) % 2) == 0);
        cycle();
        if (bus.S && !s_prev) begin
          s_rises++;
          if (first_s < 0) first_s = i;
        end
        if (bus.R) r_seen++;
        s_prev = bus.S;
      end
      n_chk++;
      if (first_s != 79) begin
        n_fail++;
        $display("FAIL bounce_start: got edge %0d want 79", first_s);
      end
      n_chk++;
      if (s_rises != 1) begin
        n_fail++;
        $display("FAIL bounce_count: got %0d want 1", s_rises);
      end
      n_chk++;
      if (r_seen != 0) begin
        n_fail++;
        $display("FAIL bounce_r: got %0d R cycles want 0", r_seen);
      end
      chk("bounce_wait_rel", outs(), 5'b00011);
      bus.set_btn = 1'b0;
      for (int i = 0; i < 40; i++) cycle();
      chk("bounce_idle", outs(), 5'b00001);
    end
`endif

    begin
      int   waited;
      logic seen;
      bus.set_btn = 1'b1;
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 60) begin
        cycle();
        waited++;
        seen = bus.En;
      end
      n_chk++;
      if (!seen) begin
        n_fail++;
        $display("FAIL mid_wait_en: got En=0 after %0d cycles want 1",
                 waited);
      end
      chk("mid_before_rst", outs(), 5'b10111);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_async_rst", outs(), 5'b00000);
      bus.set_btn = 1'b0;
      cycle();
      cycle();
      chk("mid_rst_held", outs(), 5'b00000);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        cycle();
        chk($sformatf("post_rst_idle_%0d", i), outs(), 5'b00000);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
